grid_render_sequencer: RTL
==========================

# grid_render_sequencer

Sequencing controller that rebuilds the playfield grid RAM after each game-logic step. On a start pulse from the game-logic block it clears every cell, writes the apple, streams the tail positions out of tail memory, writes the head, then reports completion. It sits between the game-logic/tail-memory side and the VGA-side grid RAM, and owns that RAM's write port.

## Interface
Parameters:
- GRID_WIDTH, 40, cells per row
- GRID_HEIGHT, 30, cells per column
- POS_W, 12, width of a linear cell position (pos = y*GRID_WIDTH + x)
- TAIL_AW, 6, tail-memory address width
- MAX_TAILS, 63, largest legal tail count
- TAIL_RD_LAT, 1, tail-memory read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level from game logic; rising edge requests a rebuild
- num_tails  in  TAIL_AW  tails to draw
- apple_pos  in  POS_W  apple cell
- head_pos  in  POS_W  head cell
- tail_addr  out  TAIL_AW  tail-memory read address
- tail_rd  out  1  tail-memory read strobe
- tail_pos  in  POS_W  tail-memory read data, valid TAIL_RD_LAT cycles after tail_rd
- grid_we  out  1  grid RAM write enable
- grid_waddr  out  POS_W  grid RAM write address
- grid_wdata  out  2  entity code: 00 apple, 01 head, 10 tail, 11 empty
- busy  out  1  rebuild in progress
- done  out  1  one-cycle pulse, rebuild complete
- pos_err  out  1  sticky: an out-of-range position was dropped

## Operation
- Rising edge of start detected internally (registered start_q). apple_pos, head_pos and min(num_tails, MAX_TAILS) are snapshotted on the detect cycle; later input changes are ignored until the next run.
- FSM: IDLE -> CLEAR -> APPLE -> TAIL -> HEAD -> DONE -> IDLE.
- CLEAR: write 11 to addresses 0..GRID_WIDTH*GRID_HEIGHT-1, one per cycle.
- APPLE: one write of 00 at apple_pos.
- TAIL: issue tail_rd with tail_addr 0..n-1, one per cycle; a delay line of depth TAIL_RD_LAT tracks valid reads; each returning tail_pos writes 10. The state exits once all n writes have drained. n = 0: TAIL is skipped (APPLE -> HEAD).
- HEAD: one write of 01 at head_pos. The head is written last, so it overwrites a coincident apple or tail.
- DONE: done = 1 for one cycle, busy falls the next cycle.
- Any position >= GRID_WIDTH*GRID_HEIGHT: no write (grid_we held 0 that cycle), pos_err set. pos_err is cleared only by reset or by a start edge.
- Start edge while busy: latched into a single pending flag. After DONE the FSM re-enters CLEAR directly with a fresh snapshot. Further edges while pending collapse into one.

## Timing
- Reset (async assert, sync release): FSM IDLE; all outputs 0, including grid_we, tail_rd, busy, done, pos_err, pending and the bank select.
- Start edge seen in cycle 0; busy = 1 from cycle 1; first CLEAR write in cycle 1.
- Total run, start detect to done: W*H + 1 + (n > 0 ? n + TAIL_RD_LAT : 0) + 1 + 1 cycles.
- Reset mid-run: stops writes immediately; the grid contents are undefined and are rebuilt by the next start.
- grid_we, grid_waddr and grid_wdata are registered outputs, so all three change together.

## Configuration
- GRID_DOUBLE_BUFFER_EN defined: grid_waddr widens to POS_W+1, with MSB = back-bank index. New output disp_bank (1 bit, reset 0) selects the front bank for the VGA reader. Writes always target !disp_bank. disp_bank toggles in the DONE cycle, so the display never sees a partial frame.
- GRID_DOUBLE_BUFFER_EN undefined: single bank, no disp_bank. The display may show a partial frame during a rebuild.

## Structure
- Shared package/header: entity codes (ENT_APPLE, ENT_HEAD, ENT_TAIL, ENT_EMPTY), FSM state encoding, and the GRID_WIDTH, GRID_HEIGHT and POS_W defaults, shared with the game logic and VGA renderer.
- One sub-module: tail_rd_pipe, a TAIL_RD_LAT-deep valid shift register that aligns tail_rd with returning tail_pos.

## Test plan
- Reset, then start with apple 5, head 47, n = 0: 1200 writes of 11, then 00@5, then 01@47. done at cycle 1203; no tail_rd.
- n = 3, tails {48, 49, 89}, TAIL_RD_LAT = 2: tail_rd addrs 0, 1, 2 in consecutive cycles; 10 written at 48, 49, 89 starting 2 cycles later; head written after the last tail.
- Head = apple = 100: final write to cell 100 is 01.
- Tail pos 1200 (out of range): no write for that tail, pos_err = 1; the next start edge clears pos_err.
- Second start edge mid-CLEAR, then a third: exactly one extra full run after done; two done pulses total.
- With GRID_DOUBLE_BUFFER_EN: first run writes bank 1 and disp_bank goes 0 -> 1 in the DONE cycle; second run writes bank 0. Assert rst_n low mid-TAIL: grid_we drops at once and disp_bank returns to 0.

Source files
------------

// File: rtl/grid_render_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// grid_render_sequencer_pkg
// Definitions shared by the game logic, the grid render sequencer and the VGA
// renderer:
//   - default playfield geometry (DEF_GRID_WIDTH, DEF_GRID_HEIGHT, DEF_POS_W)
//   - entity codes stored in each grid RAM cell (entity_e)
//   - render sequencer FSM state encoding (state_e)
// ----------------------------------------------------------------------------
package grid_render_sequencer_pkg;

    localparam int DEF_GRID_WIDTH  = 40;
    localparam int DEF_GRID_HEIGHT = 30;
    localparam int DEF_POS_W       = 12;

    typedef enum logic [1:0] {
        ENT_APPLE = 2'b00,
        ENT_HEAD  = 2'b01,
        ENT_TAIL  = 2'b10,
        ENT_EMPTY = 2'b11
    } entity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_APPLE,
        ST_TAIL,
        ST_HEAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/grid_render_sequencer_tail_rd_pipe.sv
// ----------------------------------------------------------------------------
// grid_render_sequencer_tail_rd_pipe
// LAT-deep valid shift register. A read strobe entering on in_valid appears on
// out_valid exactly LAT cycles later, in the same cycle the tail memory
// presents the matching read data.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    read strobe issued to the tail memory
//   out_valid   read data valid this cycle
// ----------------------------------------------------------------------------
module grid_render_sequencer_tail_rd_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic out_valid
);

    logic [LAT-1:0] sr;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | LAT'(in_valid);
        end
    end

    assign out_valid = sr[LAT-1];

endmodule

// File: rtl/grid_render_sequencer.sv
// ----------------------------------------------------------------------------
// grid_render_sequencer
// Rebuilds the playfield grid RAM after each game-logic step: clears every
// cell, writes the apple, streams the tail positions out of tail memory,
// writes the head last, then pulses done. Owns the grid RAM write port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 level; a rising edge requests a rebuild
//   num_tails             tails to draw (clamped to MAX_TAILS)
//   apple_pos, head_pos   linear cell positions (y*GRID_WIDTH + x)
//   tail_addr, tail_rd    tail-memory read address / strobe
//   tail_pos              tail-memory read data, TAIL_RD_LAT cycles after tail_rd
//   grid_we/waddr/wdata   registered grid RAM write port
//   busy, done            rebuild in progress / one-cycle completion pulse
//   pos_err               sticky: an out-of-range position was dropped
//
// Configuration macro GRID_DOUBLE_BUFFER_EN:
//   defined   - grid_waddr gains a bank MSB; writes target !disp_bank and
//               disp_bank (front bank for the VGA reader) flips on done.
//   undefined - single bank, no disp_bank port.
// ----------------------------------------------------------------------------
module grid_render_sequencer
    import grid_render_sequencer_pkg::*;
#(
    parameter int GRID_WIDTH  = DEF_GRID_WIDTH,
    parameter int GRID_HEIGHT = DEF_GRID_HEIGHT,
    parameter int POS_W       = DEF_POS_W,
    parameter int TAIL_AW     = 6,
    parameter int MAX_TAILS   = 63,
    parameter int TAIL_RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TAIL_AW-1:0] num_tails,
    input  logic [POS_W-1:0]   apple_pos,
    input  logic [POS_W-1:0]   head_pos,
    output logic [TAIL_AW-1:0] tail_addr,
    output logic               tail_rd,
    input  logic [POS_W-1:0]   tail_pos,
    output logic               grid_we,
`ifdef GRID_DOUBLE_BUFFER_EN
    output logic [POS_W:0]     grid_waddr,
    output logic               disp_bank,
`else
    output logic [POS_W-1:0]   grid_waddr,
`endif
    output logic [1:0]         grid_wdata,
    output logic               busy,
    output logic               done,
    output logic               pos_err
);

    localparam int                 CELLS     = GRID_WIDTH * GRID_HEIGHT;
    localparam logic [POS_W:0]     CELL_LIM  = (POS_W+1)'(CELLS);
    localparam logic [POS_W-1:0]   LAST_CELL = POS_W'(CELLS - 1);
    localparam logic [TAIL_AW-1:0] MAX_T     = TAIL_AW'(MAX_TAILS);

    state_e             state;
    logic               start_q;
    logic               pending;
    logic [POS_W-1:0]   apple_q, head_q, clr_cnt;
    logic [TAIL_AW-1:0] n_q, rd_cnt, wr_cnt;

    logic               start_edge, run_go, rd_valid;
    logic               wr_req, wr_ok;
    logic [POS_W-1:0]   wr_pos;
    entity_e            wr_code;
    logic [TAIL_AW-1:0] n_clamped;

    function automatic logic in_range(input logic [POS_W-1:0] p);
        return {1'b0, p} < CELL_LIM;
    endfunction

    assign start_edge = start & ~start_q;
    // A queued request restarts the run straight out of the done cycle.
    assign run_go     = start_edge | pending;
    assign n_clamped  = (num_tails > MAX_T) ? MAX_T : num_tails;

    grid_render_sequencer_tail_rd_pipe #(
        .LAT (TAIL_RD_LAT)
    ) u_tail_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (tail_rd),
        .out_valid (rd_valid)
    );

    // Which write (if any) the next clock edge issues to the grid RAM.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_req  = 1'b0;
        wr_pos  = clr_cnt;
        wr_code = ENT_EMPTY;
        case (state)
            ST_IDLE:  begin wr_req = run_go;   wr_pos = '0;                           end
            ST_CLEAR: begin wr_req = 1'b1;                                            end
            ST_APPLE: begin wr_req = 1'b1;     wr_pos = apple_q;  wr_code = ENT_APPLE; end
            ST_TAIL:  begin wr_req = rd_valid; wr_pos = tail_pos; wr_code = ENT_TAIL;  end
            ST_HEAD:  begin wr_req = 1'b1;     wr_pos = head_q;   wr_code = ENT_HEAD;  end
            default:  ;
        endcase
        wr_ok = wr_req & in_range(wr_pos);
    end

    // NOTE: every flop including the snapshot registers is reset; nothing here
    // is a RAM array, so a reset costs nothing and keeps outputs known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            start_q    <= 1'b0;
            pending    <= 1'b0;
            apple_q    <= '0;
            head_q     <= '0;
            clr_cnt    <= '0;
            n_q        <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            tail_addr  <= '0;
            tail_rd    <= 1'b0;
            grid_we    <= 1'b0;
            grid_waddr <= '0;
            grid_wdata <= ENT_APPLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pos_err    <= 1'b0;
`ifdef GRID_DOUBLE_BUFFER_EN
            disp_bank  <= 1'b0;
`endif
        end else begin
            start_q <= start;
            tail_rd <= 1'b0;
            done    <= 1'b0;

            grid_we <= wr_ok;
            if (wr_req) begin
`ifdef GRID_DOUBLE_BUFFER_EN
                grid_waddr <= {~disp_bank, wr_pos};
`else
                grid_waddr <= wr_pos;
`endif
                grid_wdata <= wr_code;
            end

            // A dropped write in the same cycle as a start edge still flags.
            if (start_edge)
                pos_err <= 1'b0;
            if (wr_req && !wr_ok)
                pos_err <= 1'b1;

            if (state != ST_IDLE && start_edge)
                pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (run_go) begin
                        apple_q <= apple_pos;
                        head_q  <= head_pos;
                        n_q     <= n_clamped;
                        clr_cnt <= POS_W'(1);
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_CLEAR;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + POS_W'(1);
                    if (clr_cnt == LAST_CELL)
                        state <= ST_APPLE;
                end
                ST_APPLE: begin
                    // First tail read goes out alongside the apple write.
                    if (n_q != '0) begin
                        tail_rd   <= 1'b1;
                        tail_addr <= '0;
                        rd_cnt    <= TAIL_AW'(1);
                        wr_cnt    <= '0;
                        state     <= ST_TAIL;
                    end else begin
                        state <= ST_HEAD;
                    end
                end
                ST_TAIL: begin
                    if (rd_cnt < n_q) begin
                        tail_rd   <= 1'b1;
                        tail_addr <= rd_cnt;
                        rd_cnt    <= rd_cnt + TAIL_AW'(1);
                    end
                    if (rd_valid) begin
                        wr_cnt <= wr_cnt + TAIL_AW'(1);
                        if (wr_cnt == n_q - TAIL_AW'(1))
                            state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
`ifdef GRID_DOUBLE_BUFFER_EN
                    disp_bank <= ~disp_bank;
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
